// File: rtl/branch_update_unit_if.sv
// Bundle between the execute stage, the PC generator and the predictor tables
// (BHT/PHT/BTB) for the branch update unit.
interface branch_update_unit_if;
  // Resolved-branch handshake: a record moves on a rising edge where
  // br_valid && br_ready; br_valid may drop or change freely when ready is low.
  logic        br_valid;
  logic        br_ready;
  logic [31:0] br_pc;
  logic        br_taken;
  logic [31:0] br_target;
  logic [1:0]  br_type;
  logic        br_pred_taken;
  logic [31:0] br_pred_target;

  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic [9:0]  bht_ridx;
  logic [4:0]  bht_rdata;
  logic [4:0]  pht_ridx;
  logic [1:0]  pht_rdata;

  logic        bht_we;
  logic [9:0]  bht_widx;
  logic [4:0]  bht_wdata;
  logic        pht_we;
  logic [4:0]  pht_widx;
  logic [1:0]  pht_wdata;
  logic        btb_we;
  logic [9:0]  btb_widx;
  logic [9:0]  btb_wtag;
  logic [31:0] btb_wtarget;
  logic [1:0]  btb_wtype;

  modport slave (
    input  br_valid, br_pc, br_taken, br_target, br_type, br_pred_taken, br_pred_target,
    input  bht_rdata, pht_rdata,
    output br_ready, redirect_valid, redirect_pc, bht_ridx, pht_ridx,
    output bht_we, bht_widx, bht_wdata, pht_we, pht_widx, pht_wdata,
    output btb_we, btb_widx, btb_wtag, btb_wtarget, btb_wtype
  );

  modport master (
    output br_valid, br_pc, br_taken, br_target, br_type, br_pred_taken, br_pred_target,
    output bht_rdata, pht_rdata,
    input  br_ready, redirect_valid, redirect_pc, bht_ridx, pht_ridx,
    input  bht_we, bht_widx, bht_wdata, pht_we, pht_widx, pht_wdata,
    input  btb_we, btb_widx, btb_wtag, btb_wtarget, btb_wtype
  );
endinterface

// File: rtl/branch_update_unit.sv
// Buffers resolved branches, raises mispredict redirects immediately and
// retires each record into the BHT/PHT/BTB through an IDLE/LOOKUP/WRITE walk.
module branch_update_unit #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  branch_update_unit_if.slave bus,
  output logic [1:0]          dbg_state_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, LOOKUP = 2'd1, WRITE = 2'd2} state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
    logic [1:0]  btype;
  } rec_t;

  rec_t          fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  state_e        state_q;
  rec_t          work_q;
  logic [4:0]    hist_q;
  logic [1:0]    ctr_q;

  logic          redir_valid_q, redir_valid_d;
  logic [31:0]   redir_pc_q, redir_pc_d;

  logic          full, empty, push, pop, mispredict, wr_en;
  logic [9:0]    lookup_idx;
  logic [1:0]    ctr_next;
  rec_t          in_rec;

  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign bus.br_ready = !rst && !full;
  assign push  = bus.br_valid && bus.br_ready;
  assign pop   = (state_q == IDLE) && !empty;

  assign in_rec = '{pc: bus.br_pc, taken: bus.br_taken, target: bus.br_target,
                    btype: bus.br_type};

  // Redirect is decided on the accepted record itself, never waiting on the FSM.
  assign mispredict = (bus.br_taken != bus.br_pred_taken) ||
                      (bus.br_taken && (bus.br_target != bus.br_pred_target));

  always_comb begin
    redir_valid_d = push && mispredict;
    redir_pc_d    = bus.br_taken ? bus.br_target : bus.br_pc + 32'd4;
    wr_ptr_d      = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d      = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d       = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= in_rec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (!empty) begin
            work_q  <= fifo_q[rd_ptr_q];
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          hist_q  <= bus.bht_rdata;
          ctr_q   <= bus.pht_rdata;
          state_q <= WRITE;
        end
        WRITE:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Counter order along the taken direction is 01 -> 00 -> 10 -> 11.
  always_comb begin
    ctr_next = ctr_q;
    if (work_q.taken) begin
      case (ctr_q)
        2'b01:   ctr_next = 2'b00;
        2'b00:   ctr_next = 2'b10;
        default: ctr_next = 2'b11;
      endcase
    end else begin
      case (ctr_q)
        2'b11:   ctr_next = 2'b10;
        2'b10:   ctr_next = 2'b00;
        default: ctr_next = 2'b01;
      endcase
    end
  end

  assign lookup_idx = work_q.pc[21:12] ^ work_q.pc[11:2];
  // Reset in WRITE must suppress the strobes within that very cycle.
  assign wr_en      = (state_q == WRITE) && !rst;

  assign bus.redirect_valid = redir_valid_q;
  assign bus.redirect_pc    = redir_pc_q;
  assign bus.bht_ridx       = lookup_idx;
  assign bus.pht_ridx       = bus.bht_rdata;
  assign bus.bht_we         = wr_en;
  assign bus.bht_widx       = lookup_idx;
  assign bus.bht_wdata      = {hist_q[3:0], work_q.taken};
  assign bus.pht_we         = wr_en;
  assign bus.pht_widx       = hist_q;
  assign bus.pht_wdata      = ctr_next;
  assign bus.btb_we         = wr_en && work_q.taken;
  assign bus.btb_widx       = work_q.pc[11:2];
  assign bus.btb_wtag       = work_q.pc[21:12];
  assign bus.btb_wtarget    = work_q.target;
  assign bus.btb_wtype      = work_q.btype;
  assign dbg_state_o        = state_q;
endmodule

// File: tb/tb_branch_update_unit.sv
// Directed bench for branch_update_unit: redirects, table-write contents and
// timing, FIFO back-pressure ordering, and reset behaviour.
module tb_branch_update_unit;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [9:0] exp_q[$];
  logic       mon_en = 1'b0;

  branch_update_unit_if bus();

  branch_update_unit #(.FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic send_br(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                         input logic [1:0] typ, input logic pt, input logic [31:0] ptgt);
    int waits;
    @(negedge clk);
    bus.br_pc = pc; bus.br_taken = taken; bus.br_target = tgt; bus.br_type = typ;
    bus.br_pred_taken = pt; bus.br_pred_target = ptgt; bus.br_valid = 1'b1;
    waits = 0;
    while (!bus.br_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 20) check("send_timeout", 1, 0);
    @(posedge clk);
    #1 bus.br_valid = 1'b0;
  endtask

  task automatic run_one(input string tag, input logic [31:0] pc, input logic taken,
                         input logic [31:0] tgt, input logic [1:0] typ, input logic pt,
                         input logic [31:0] ptgt, input logic [4:0] hist, input logic [1:0] ctr,
                         input logic exp_redir, input logic [31:0] exp_rpc,
                         input logic [9:0] exp_bidx, input logic [4:0] exp_bdata,
                         input logic [1:0] exp_pdata, input logic exp_btb,
                         input logic [9:0] exp_tidx, input logic [9:0] exp_tag);
    bus.bht_rdata = hist;
    bus.pht_rdata = ctr;
    send_br(pc, taken, tgt, typ, pt, ptgt);
    @(negedge clk);
    check({tag, "_redir_v"}, bus.redirect_valid, exp_redir);
    if (exp_redir) check({tag, "_redir_pc"}, bus.redirect_pc, exp_rpc);
    @(negedge clk);
    check({tag, "_redir_pulse"}, bus.redirect_valid, 0);
    check({tag, "_lookup_state"}, dbg_state, 1);
    check({tag, "_bht_ridx"}, bus.bht_ridx, exp_bidx);
    check({tag, "_pht_ridx"}, bus.pht_ridx, hist);
    @(negedge clk);
    check({tag, "_bht_we"}, bus.bht_we, 1);
    check({tag, "_bht_widx"}, bus.bht_widx, exp_bidx);
    check({tag, "_bht_wdata"}, bus.bht_wdata, exp_bdata);
    check({tag, "_pht_we"}, bus.pht_we, 1);
    check({tag, "_pht_widx"}, bus.pht_widx, hist);
    check({tag, "_pht_wdata"}, bus.pht_wdata, exp_pdata);
    check({tag, "_btb_we"}, bus.btb_we, exp_btb);
    if (exp_btb) begin
      check({tag, "_btb_widx"}, bus.btb_widx, exp_tidx);
      check({tag, "_btb_wtag"}, bus.btb_wtag, exp_tag);
      check({tag, "_btb_wtarget"}, bus.btb_wtarget, tgt);
      check({tag, "_btb_wtype"}, bus.btb_wtype, typ);
    end
    @(negedge clk);
    check({tag, "_we_clear"}, {bus.bht_we, bus.pht_we, bus.btb_we}, 0);
  endtask

  // Back-to-back write monitor: BHT write indices must retire in accept order.
  always @(negedge clk) begin
    if (mon_en && bus.bht_we) begin
      if (exp_q.size() == 0) begin
        check("b2b_extra_write", 1, 0);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        check("b2b_order", bus.bht_widx, e);
      end
    end
  end

  initial begin
    int accepted;
    int waits;
    int wr_seen;
    logic saw_full;

    bus.br_valid = 1'b0; bus.br_pc = '0; bus.br_taken = 1'b0; bus.br_target = '0;
    bus.br_type = '0; bus.br_pred_taken = 1'b0; bus.br_pred_target = '0;
    bus.bht_rdata = '0; bus.pht_rdata = '0;

    @(negedge clk);
    check("rst_ready_low", bus.br_ready, 0);
    check("rst_state_idle", dbg_state, 0);
    check("rst_redirect", bus.redirect_valid, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", bus.br_ready, 1);
    check("post_rst_we", {bus.bht_we, bus.pht_we, bus.btb_we}, 0);

    run_one("nt_correct", 32'h1C000010, 1'b0, 32'h0, 2'b01, 1'b0, 32'h0, 5'b00011, 2'b01,
            1'b0, 32'h0, 10'h004, 5'b00110, 2'b01, 1'b0, 10'h0, 10'h0);
    run_one("t_mispred", 32'h1C000020, 1'b1, 32'h1C000100, 2'b01, 1'b0, 32'h0, 5'b10101, 2'b00,
            1'b1, 32'h1C000100, 10'h008, 5'b01011, 2'b10, 1'b1, 10'h008, 10'h000);
    run_one("nt_mispred", 32'h1C000040, 1'b0, 32'h0, 2'b01, 1'b1, 32'h1C000080, 5'b01010, 2'b11,
            1'b1, 32'h1C000044, 10'h010, 5'b10100, 2'b10, 1'b0, 10'h0, 10'h0);
    run_one("tgt_mispred", 32'h1C003008, 1'b1, 32'h1C000200, 2'b11, 1'b1, 32'h1C000300, 5'b01100,
            2'b10, 1'b1, 32'h1C000200, 10'h001, 5'b11001, 2'b11, 1'b1, 10'h002, 10'h003);
    run_one("pc_wrap", 32'hFFFFFFFC, 1'b0, 32'h0, 2'b00, 1'b1, 32'h0, 5'b11111, 2'b01,
            1'b1, 32'h00000000, 10'h000, 5'b11110, 2'b01, 1'b0, 10'h0, 10'h0);

    // Two consecutive mispredicts: redirects follow accepts, not the FSM.
    @(negedge clk);
    bus.br_pc = 32'h11110000; bus.br_taken = 1'b1; bus.br_target = 32'h12340000;
    bus.br_pred_taken = 1'b0; bus.br_valid = 1'b1;
    check("bb_ready_a", bus.br_ready, 1);
    @(negedge clk);
    check("bb_redir_a_v", bus.redirect_valid, 1);
    check("bb_redir_a_pc", bus.redirect_pc, 32'h12340000);
    bus.br_pc = 32'h22220000; bus.br_taken = 1'b0; bus.br_pred_taken = 1'b1;
    check("bb_ready_b", bus.br_ready, 1);
    @(negedge clk);
    check("bb_redir_b_v", bus.redirect_valid, 1);
    check("bb_redir_b_pc", bus.redirect_pc, 32'h22220004);
    bus.br_valid = 1'b0;
    @(negedge clk);
    check("bb_redir_end", bus.redirect_valid, 0);
    repeat (10) @(negedge clk);

    // Eight cycles of back-to-back valid into a depth-4 FIFO.
    bus.bht_rdata = '0; bus.pht_rdata = 2'b01; bus.br_taken = 1'b0; bus.br_pred_taken = 1'b0;
    accepted = 0; saw_full = 1'b0; mon_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.br_valid = 1'b1;
      bus.br_pc = 32'h1C000100 + 32'(accepted * 4);
      if (bus.br_ready) begin
        exp_q.push_back(10'h040 + 10'(accepted));
        accepted++;
      end else begin
        saw_full = 1'b1;
      end
    end
    @(negedge clk);
    bus.br_valid = 1'b0;
    waits = 0;
    while (exp_q.size() != 0 && waits < 60) begin
      @(negedge clk);
      waits++;
    end
    repeat (6) @(negedge clk);
    mon_en = 1'b0;
    check("b2b_drained", exp_q.size(), 0);
    check("b2b_backpressure", saw_full, 1);
    check("b2b_accepts_range", (accepted >= 4 && accepted <= 6), 1);

    // Reset while in WRITE with a second record still queued.
    bus.bht_rdata = 5'b00001; bus.pht_rdata = 2'b10;
    send_br(32'h1C000400, 1'b1, 32'h1C000500, 2'b01, 1'b1, 32'h1C000500);
    send_br(32'h1C000404, 1'b1, 32'h1C000600, 2'b01, 1'b1, 32'h1C000600);
    waits = 0;
    @(negedge clk);
    while (dbg_state != 2'd2 && waits < 10) begin
      @(negedge clk);
      waits++;
    end
    check("rw_reached_write", dbg_state, 2);
    rst = 1'b1;
    #1;
    check("rw_no_we", {bus.bht_we, bus.pht_we, bus.btb_we}, 0);
    check("rw_ready_low", bus.br_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rw_state_idle", dbg_state, 0);
    check("rw_ready_high", bus.br_ready, 1);
    wr_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.bht_we || bus.pht_we || bus.btb_we) wr_seen++;
    end
    check("rw_queue_discarded", wr_seen, 0);
    check("rw_still_idle", dbg_state, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
